// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver feeding the host command decoder.
// The serial line is synchronized and sampled at bit centres. Good bytes
// appear on DataOut with a one-cycle ByteRdy pulse. ByteCLK rises one
// cycle after DataOut settles, so the decoder sees stable data on both
// of its edges. A low stop bit raises FrameErr, and the receiver then
// waits for the line to go idle before looking for another start bit.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STRB_LEN     = 8
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       RXD,
  output logic [7:0] DataOut,
  output logic       ByteRdy,
  output logic       ByteCLK,
  output logic       FrameErr,
  output logic       RxActive
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int STRB_W = $clog2(STRB_LEN + 1);

  localparam logic [CNT_W-1:0]  FULL_BIT  = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [STRB_W-1:0] STRB_LAST = STRB_W'(STRB_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic              rx_p0;
  logic              rx_p1;
  logic              rxs;
  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              cnt_done;
  logic [STRB_W-1:0] strb_cnt;
  logic              strb_restart;

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous line ----
  // Bring RXD into the CLK domain; resets to the idle (high) level.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= RXD;
      rx_p1 <= rx_p0;
    end
  end

  assign rxs      = rx_p1;
  // The bit timer counts down. It expires on the cycle it holds 1, so a
  // load of N places the sample exactly N cycles later.
  assign cnt_done = (bit_cnt == CNT_W'(1));

  // ---- frame FSM: start detect, bit-centre sampling, stop check ----
  // Receive one 8N1 frame per pass. All outputs of this block are registered.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      DataOut   <= '0;
      ByteRdy   <= 1'b0;
      FrameErr  <= 1'b0;
      RxActive  <= 1'b0;
    end else begin
      ByteRdy  <= 1'b0;
      FrameErr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            bit_cnt  <= HALF_BIT;
            state    <= S_START;
            RxActive <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_done) begin
            if (rxs) begin
              // Line went back high before mid-bit: treat it as a glitch.
              bit_cnt  <= '0;
              RxActive <= 1'b0;
              state    <= S_IDLE;
            end else begin
              bit_cnt <= FULL_BIT;
              bit_idx <= '0;
              state   <= S_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt_done) begin
            shift_reg <= {rxs, shift_reg[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            bit_cnt   <= FULL_BIT;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt_done) begin
            bit_cnt  <= '0;
            RxActive <= 1'b0;
            if (rxs) begin
              // Return to IDLE at mid stop bit so a back-to-back start edge is caught.
              DataOut <= shift_reg;
              ByteRdy <= 1'b1;
              state   <= S_IDLE;
            end else begin
              FrameErr <= 1'b1;
              state    <= S_BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        S_BREAK: begin
          // A held-low line must not be decoded as a stream of 0x00 bytes.
          if (rxs) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- strobe stage: ByteCLK follows ByteRdy by one cycle ----
  // Stretch each ByteRdy into a STRB_LEN-cycle ByteCLK high period. If a new
  // byte arrives mid-strobe, insert one low cycle before restarting.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      ByteCLK      <= 1'b0;
      strb_cnt     <= '0;
      strb_restart <= 1'b0;
    end else if (ByteRdy) begin
      if (ByteCLK) begin
        ByteCLK      <= 1'b0;
        strb_cnt     <= '0;
        strb_restart <= 1'b1;
      end else begin
        ByteCLK      <= 1'b1;
        strb_cnt     <= STRB_LAST;
        strb_restart <= 1'b0;
      end
    end else if (strb_restart) begin
      ByteCLK      <= 1'b1;
      strb_cnt     <= STRB_LAST;
      strb_restart <= 1'b0;
    end else if (ByteCLK) begin
      if (strb_cnt == '0) begin
        ByteCLK <= 1'b0;
      end else begin
        strb_cnt <= strb_cnt - STRB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx. Stimulus tasks serialize bytes onto RXD and
// queue the receive events they should cause. A negedge checker compares
// DataOut, ByteCLK, ByteRdy and FrameErr against that queue on every cycle.
module tb_uart_byte_rx;

  localparam int CPB = 16;
  localparam int SL  = 4;
  // One clock period is 100 time units, so a nominal bit is CPB*100 units.
  localparam longint LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic       CLK;
  logic       CLR;
  logic       RXD;
  logic [7:0] DataOut;
  logic       ByteRdy;
  logic       ByteCLK;
  logic       FrameErr;
  logic       RxActive;

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .STRB_LEN(SL)) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .RXD      (RXD),
    .DataOut  (DataOut),
    .ByteRdy  (ByteRdy),
    .ByteCLK  (ByteCLK),
    .FrameErr (FrameErr),
    .RxActive (RxActive)
  );

  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         chk_lat;
    longint     t0;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ck_ev;
  int         n_chk = 0;
  int         n_fail = 0;
  longint     cyc = 0;
  logic [7:0] model_data = 8'h00;
  int         since_rdy = 1000;
  longint     last_rdy_cyc = 0;
  logic [7:0] last_rdy_data = 8'h00;
  int         clk_run = 0;
  int         last_clk_run = 0;
  int         rdy_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] seq4 [4];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Serialize one 8N1 frame; s_pct skews the bit period by that many percent.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int s_pct,
                            input bit lat);
    int unsigned bt;
    ev_t ev;
    bt = CPB * (100 + s_pct);
    ev.err = !stop_ok;
    ev.data = b;
    ev.chk_lat = lat;
    ev.t0 = cyc;
    exp_q.push_back(ev);
    RXD = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      #(bt);
    end
    RXD = stop_ok;
    #(bt);
  endtask

  // Reference model and per-cycle comparison
  always @(negedge CLK) begin
    if (CLR) begin
      model_data = 8'h00;
      since_rdy = 1000;
      exp_q.delete();
      clk_run = 0;
    end else begin
      if (since_rdy < 1000) since_rdy++;
      if (ByteRdy === 1'b1 || FrameErr === 1'b1) begin
        chk("rdy_ferr_exclusive", 64'(ByteRdy & FrameErr), 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 64'({ByteRdy, FrameErr}), 64'd0);
        end else begin
          ck_ev = exp_q.pop_front();
          chk("event_is_ferr", 64'(FrameErr), 64'(ck_ev.err));
          if (ck_ev.chk_lat) chk("event_latency", 64'(cyc - ck_ev.t0), 64'(LAT));
          if (!ck_ev.err) model_data = ck_ev.data;
        end
        if (ByteRdy) begin
          since_rdy = 0;
          rdy_cnt++;
          last_rdy_cyc = cyc;
          last_rdy_data = DataOut;
        end
        if (FrameErr) ferr_cnt++;
      end
      chk("data_out", 64'(DataOut), 64'(model_data));
      chk("byte_clk", 64'(ByteCLK), 64'(since_rdy >= 1 && since_rdy <= SL));
      if (ByteCLK) begin
        clk_run++;
      end else if (clk_run != 0) begin
        last_clk_run = clk_run;
        clk_run = 0;
      end
    end
  end

  initial begin
    #(90000 * 100);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int     act;
    int     r0;
    int     f0;
    longint t0;
    int     s;

    seq4 = '{8'hA5, 8'hE3, 8'h07, 8'hA5};
    RXD = 1'b1;
    CLR = 1'b1;
    repeat (3) @(negedge CLK);
    @(negedge CLK);
    #25 CLR = 1'b0;
    @(negedge CLK);
    chk("reset_dataout", 64'(DataOut), 64'h00);
    chk("reset_byterdy", 64'(ByteRdy), 64'd0);
    chk("reset_byteclk", 64'(ByteCLK), 64'd0);
    chk("reset_frameerr", 64'(FrameErr), 64'd0);
    chk("reset_rxactive", 64'(RxActive), 64'd0);
    repeat (4) @(negedge CLK);

    // Single byte 0x3C with exact timing
    @(negedge CLK);
    t0 = cyc;
    act = 0;
    fork
      send_frame(8'h3C, 1'b1, 0, 1'b1);
      begin
        repeat (11 * CPB) begin
          @(negedge CLK);
          if (RxActive) act++;
        end
      end
    join
    repeat (10) @(negedge CLK);
    chk("lat_3c", 64'(last_rdy_cyc - t0), 64'd155);
    chk("data_3c", 64'(last_rdy_data), 64'h3C);
    chk("strobe_len_3c", 64'(last_clk_run), 64'd4);
    chk("rdy_count_3c", 64'(rdy_cnt), 64'd1);
    chk("ferr_count_3c", 64'(ferr_cnt), 64'd0);
    chk("rxactive_len_3c", 64'(act), 64'd152);

    // Back-to-back frames, one stop bit each
    @(negedge CLK);
    r0 = rdy_cnt;
    for (int i = 0; i < 4; i++) send_frame(seq4[i], 1'b1, 0, 1'b1);
    repeat (2 * CPB) @(negedge CLK);
    chk("b2b_rdy_count", 64'(rdy_cnt - r0), 64'd4);
    chk("b2b_last_data", 64'(last_rdy_data), 64'hA5);

    // Short low glitch is a false start
    @(negedge CLK);
    r0 = rdy_cnt;
    act = 0;
    RXD = 1'b0;
    fork
      begin
        repeat (6) @(negedge CLK);
        RXD = 1'b1;
      end
      begin
        repeat (3 * CPB) begin
          @(negedge CLK);
          if (RxActive) act++;
        end
      end
    join
    chk("false_start_active", 64'(act), 64'(CPB / 2));
    chk("false_start_no_rdy", 64'(rdy_cnt - r0), 64'd0);
    chk("false_start_idle", 64'(RxActive), 64'd0);

    // Low stop bit followed by a long break
    @(negedge CLK);
    r0 = rdy_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 0, 1'b1);
    repeat (40 * CPB) @(negedge CLK);
    chk("break_ferr_count", 64'(ferr_cnt - f0), 64'd1);
    chk("break_no_rdy", 64'(rdy_cnt - r0), 64'd0);
    chk("break_data_kept", 64'(DataOut), 64'hA5);
    RXD = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    send_frame(8'h81, 1'b1, 0, 1'b1);
    repeat (2 * CPB) @(negedge CLK);
    chk("after_break_data", 64'(last_rdy_data), 64'h81);

    // Asynchronous reset during data bit 4 of 0xFF
    @(negedge CLK);
    begin
      ev_t ev;
      ev.err = 1'b0;
      ev.data = 8'hFF;
      ev.chk_lat = 1'b0;
      ev.t0 = cyc;
      exp_q.push_back(ev);
    end
    RXD = 1'b0;
    #(CPB * 100);
    for (int i = 0; i < 4; i++) begin
      RXD = 1'b1;
      #(CPB * 100);
    end
    RXD = 1'b1;
    #825;
    chk("clr_pre_active", 64'(RxActive), 64'd1);
    CLR = 1'b1;
    #1;
    chk("clr_dataout", 64'(DataOut), 64'h00);
    chk("clr_byterdy", 64'(ByteRdy), 64'd0);
    chk("clr_byteclk", 64'(ByteCLK), 64'd0);
    chk("clr_frameerr", 64'(FrameErr), 64'd0);
    chk("clr_rxactive", 64'(RxActive), 64'd0);
    repeat (2) @(negedge CLK);
    #25 CLR = 1'b0;
    repeat (4) @(negedge CLK);
    send_frame(8'h12, 1'b1, 0, 1'b1);
    repeat (2 * CPB) @(negedge CLK);
    chk("after_clr_data", 64'(last_rdy_data), 64'h12);

    // Random stream with per-byte baud skew of -3..+3 percent
    @(negedge CLK);
    r0 = rdy_cnt;
    f0 = ferr_cnt;
    for (int i = 0; i < 256; i++) begin
      s = int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 3) == 0) #(16 * $urandom_range(1, 50));
      send_frame(8'($urandom_range(0, 255)), 1'b1, s, 1'b0);
    end
    repeat (4 * CPB) @(negedge CLK);
    chk("stream_rdy_count", 64'(rdy_cnt - r0), 64'd256);
    chk("stream_ferr_count", 64'(ferr_cnt - f0), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Asynchronous serial receiver that sits directly upstream of the host command decoder. It turns the host's 8N1 UART line into bytes, including the 0xA5 sync/end marker and the order and data bytes. Each received byte is presented on a stable 8-bit bus together with a stretched byte clock. The decoder consumes that bus on its own clock edges, so the byte clock only rises after the data bus is settled and stays high long enough for both decoder edges to see consistent data.

## Interface
- CLKS_PER_BIT, 434, system clocks per UART bit (50 MHz / 115200); legal range 8..65535
- STRB_LEN, 8, cycles ByteCLK stays high per byte; legal range 2..CLKS_PER_BIT
- CLK  input  1  system clock; all logic on posedge
- CLR  input  1  reset, asynchronous, active-high
- RXD  input  1  raw serial line, idle high, asynchronous to CLK
- DataOut  output  8  last good byte, LSB received first; held until the next good byte
- ByteRdy  output  1  one-cycle pulse in the cycle DataOut is updated
- ByteCLK  output  1  byte clock to the decoder; rises 1 cycle after DataOut is updated, high for STRB_LEN cycles
- FrameErr  output  1  one-cycle pulse when the stop bit samples low; DataOut is not updated
- RxActive  output  1  high from start-bit detection until the stop-bit sample or a false-start abort

## Operation
- RXD passes through a 2-flop synchronizer (reset value 1); all references below are to the synchronized value rxs.
- Reset values: DataOut=0x00, ByteRdy=0, ByteCLK=0, FrameErr=0, RxActive=0, FSM=IDLE, all counters 0.
- FSM states:
  - IDLE: on rxs==0, load the bit counter with CLKS_PER_BIT/2 (floor), go to START, and set RxActive.
  - START: when the counter expires, sample rxs.
    - rxs==1: false start; clear RxActive, no pulses, return to IDLE.
    - rxs==0: reload the counter with CLKS_PER_BIT, set bit index to 0, go to DATA.
  - DATA: on each expiry, shift rxs into the shift register MSB side (bits end up LSB-first) and increment the index. After index 7 is sampled, reload and go to STOP.
  - STOP: on expiry, sample rxs.
    - rxs==1: DataOut<=shift register, pulse ByteRdy, arm the strobe counter.
    - rxs==0: pulse FrameErr and go to BREAK.
    - In both cases, clear RxActive. A good stop goes to IDLE in the same cycle.
  - BREAK: wait for rxs==1, then go to IDLE. This stops a held-low line from being read as repeated 0x00 bytes.
- Strobe generator runs independently of the FSM:
  - Armed by ByteRdy. ByteCLK goes high the next cycle and stays high for STRB_LEN cycles, then goes low.
  - A new ByteRdy while ByteCLK is high forces ByteCLK low for 1 cycle, then restarts a full STRB_LEN high period. This cannot occur with legal parameters and 8N1 framing; it is defined behaviour only.
- No receive FIFO. The decoder's byte rate is the line rate, and there is no backpressure.
- The block does not interpret byte values; 0xA5 is passed through like any other byte.

## Timing
- Samples fall at bit centres: half a bit after the start edge is seen, then every CLKS_PER_BIT cycles.
- Latency from a falling edge on RXD to ByteRdy: 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
- FSM returns to IDLE about half a bit before the end of the stop bit, so back-to-back frames with a single stop bit are received without loss.
- DataOut is stable from 1 cycle before ByteCLK rises until at least the next ByteRdy, which is at least 9.5 bits later.
- CLR asserted mid-frame: everything returns to reset values immediately, the partial byte is discarded, and ByteCLK drops. After release, a line that is still low is treated as a start edge. This is acceptable; the sync byte resynchronizes the decoder.
- Tolerates ±3% baud mismatch. Glitches shorter than CLKS_PER_BIT/2 are rejected as false starts.

## Test plan
- CLKS_PER_BIT=16, STRB_LEN=4; send 0x3C as 8N1 -> ByteRdy pulses once, 2+8+144+1=155 cycles after the falling edge. DataOut=0x3C. ByteCLK is high for exactly 4 cycles starting the next cycle. FrameErr never asserts.
- Send 0xA5, 0xE3, 0x07, 0xA5 back-to-back with one stop bit each -> four ByteRdy pulses, with DataOut in the same order, and four ByteCLK periods that never overlap.
- Pull RXD low for 6 cycles, then high -> no ByteRdy, RxActive high for CLKS_PER_BIT/2 cycles and then low, FSM back in IDLE.
- Send 0x55 with the stop bit driven low, then hold the line low for 40 bits -> exactly one FrameErr pulse and no ByteRdy. DataOut keeps its previous value. After RXD returns high, a following 0x81 is received correctly.
- Assert CLR during data bit 4 of 0xFF -> all outputs go to reset values asynchronously (DataOut=0x00). A following 0x12 sent after release is received correctly.
- Run with ±3% baud skew on a random 256-byte stream -> all bytes match and FrameErr count is 0.
